// File: rtl/tl_phase_sched.sv
// tl_phase_sched: timed four-phase intersection scheduler with min/max green,
// yellow and all-red clearance, and demand-driven phase skipping.
module tl_phase_sched #(
   parameter int T_MIN_GREEN = 4,
   parameter int T_MAX_GREEN = 12,
   parameter int T_YELLOW    = 3,
   parameter int T_ALLRED    = 2,
   parameter int CW          = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Ta,
   input  logic       Tal,
   input  logic       Tb,
   input  logic       Tbl,
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic [1:0] phase,
   output logic       clr
);
   typedef enum logic [1:0] {G, Y, R} st_t;
   st_t st;
   logic [1:0] nxt, sel;
   logic [CW-1:0] cnt;
   logic [3:0] d;
   logic own, other, go;
   assign d = {Tbl, Tb, Tal, Ta};
   assign own = d[phase];
   assign other = |(d & ~(4'b1 << phase));
   assign go = cnt >= CW'(T_MIN_GREEN - 1) && other && (!own || cnt >= CW'(T_MAX_GREEN - 1));
   // cyclic search after the current phase; other=1 guarantees one of the three hits
   assign sel = d[phase + 2'd1] ? phase + 2'd1 : d[phase + 2'd2] ? phase + 2'd2 : phase + 2'd3;
   always_ff @(posedge clk)
      if (reset) begin
         st    <= G;
         phase <= '0;
         nxt   <= '0;
         cnt   <= '0;
      end else
         case (st)
            G:
               if (go) begin
                  st  <= Y;
                  nxt <= sel;
                  cnt <= '0;
               end else if (cnt != CW'(T_MAX_GREEN - 1))
                  cnt <= cnt + 1'b1;
            Y:
               if (cnt == CW'(T_YELLOW - 1)) begin
                  st  <= R;
                  cnt <= '0;
               end else
                  cnt <= cnt + 1'b1;
            R:
               if (cnt == CW'(T_ALLRED - 1)) begin
                  st    <= G;
                  phase <= nxt;
                  cnt   <= '0;
               end else
                  cnt <= cnt + 1'b1;
            default: begin
               st  <= G;
               cnt <= '0;
            end
         endcase
   always_comb begin
      La  = st == R ? 2'b10 : st == Y ? (phase[1] ? 2'b10 : 2'b01) :
            phase == 2'd0 ? 2'b00 : phase == 2'd1 ? 2'b11 : 2'b10;
      Lb  = st == R ? 2'b10 : st == Y ? (phase[1] ? 2'b01 : 2'b10) :
            phase == 2'd2 ? 2'b00 : phase == 2'd3 ? 2'b11 : 2'b10;
      clr = st != G;
   end
endmodule

// File: tb/tb_tl_phase_sched.sv
// tb_tl_phase_sched: scenario tasks plus randomized run against a cycle-count reference model.
module tb_tl_phase_sched;
   localparam int TMIN = 4, TMAX = 12, TY = 3, TR = 2;
   logic clk = 0, reset = 1, Ta = 0, Tal = 0, Tb = 0, Tbl = 0;
   logic [1:0] La, Lb, phase;
   logic clr;
   int total = 0, bad = 0;
   bit m_green;
   int m_age, m_clear, m_phase, m_next;
   tl_phase_sched #(.T_MIN_GREEN(TMIN), .T_MAX_GREEN(TMAX), .T_YELLOW(TY), .T_ALLRED(TR), .CW(5)) dut (
      .clk(clk), .reset(reset), .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
      .La(La), .Lb(Lb), .phase(phase), .clr(clr)
   );
   always #5 clk = ~clk;
   // model: green age counts up unbounded; clearance counts down through yellow then all-red
   task automatic model_step(input logic r, input logic [3:0] d);
      bit own;
      int nother;
      if (r) begin
         m_green = 1; m_age = 0; m_phase = 0; m_next = 0; m_clear = 0;
      end else if (m_green) begin
         own = d[m_phase];
         nother = $countones(d) - int'(own);
         if (m_age >= TMIN - 1 && nother > 0 && (!own || m_age >= TMAX - 1)) begin
            m_green = 0;
            m_clear = TY + TR;
            for (int k = 3; k >= 1; k--) if (d[(m_phase + k) % 4]) m_next = (m_phase + k) % 4;
         end else m_age++;
      end else if (m_clear == 1) begin
         m_green = 1; m_phase = m_next; m_age = 0;
      end else m_clear--;
   endtask
   function automatic logic [6:0] expv();
      logic [1:0] la, lb;
      if (m_green) begin
         la = m_phase == 0 ? 2'b00 : m_phase == 1 ? 2'b11 : 2'b10;
         lb = m_phase == 2 ? 2'b00 : m_phase == 3 ? 2'b11 : 2'b10;
      end else if (m_clear > TR) begin
         la = m_phase < 2 ? 2'b01 : 2'b10;
         lb = m_phase < 2 ? 2'b10 : 2'b01;
      end else begin
         la = 2'b10;
         lb = 2'b10;
      end
      return {la, lb, 2'(m_phase), !m_green};
   endfunction
   task automatic tick(input logic r, input logic [3:0] d);
      reset = r;
      {Tbl, Tb, Tal, Ta} = d;
      @(posedge clk);
      model_step(r, d);
      #1;
   endtask
   task automatic test_reset();
      tick(1, 4'b0000);
      for (int i = 0; i < 50; i++) begin
         tick(0, 4'b0000);
         total++;
         if ({La, Lb, phase, clr} !== 7'b00_10_00_0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {La, Lb, phase, clr}, 7'b00_10_00_0);
         end
      end
   endtask
   task automatic test_single_b();
      logic [6:0] w;
      tick(1, 4'b0000);
      for (int i = 0; i < 16; i++) begin
         tick(0, 4'b0100);
         w = i + 1 < 4 ? 7'b00_10_00_0 : i + 1 < 7 ? 7'b01_10_00_1 : i + 1 < 9 ? 7'b10_10_00_1 : 7'b10_00_10_0;
         total++;
         if ({La, Lb, phase, clr} !== w) begin
            bad++;
            $display("FAIL single_b cyc=%0d got=%b want=%b", i, {La, Lb, phase, clr}, w);
         end
      end
   endtask
   task automatic test_contested();
      logic [6:0] w;
      int p;
      tick(1, 4'b0000);
      for (int i = 0; i < 80; i++) begin
         tick(0, 4'b0101);
         p = (i + 1) % 34;
         w = p < 12 ? 7'b00_10_00_0 : p < 15 ? 7'b01_10_00_1 : p < 17 ? 7'b10_10_00_1 :
             p < 29 ? 7'b10_00_10_0 : p < 32 ? 7'b10_01_10_1 : 7'b10_10_10_1;
         total++;
         if ({La, Lb, phase, clr} !== w) begin
            bad++;
            $display("FAIL contested cyc=%0d got=%b want=%b", i, {La, Lb, phase, clr}, w);
         end
      end
   endtask
   task automatic test_skip();
      tick(1, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         tick(0, 4'b1000);
         total++;
         if ({La, Lb, phase, clr} !== expv()) begin
            bad++;
            $display("FAIL skip cyc=%0d got=%b want=%b", i, {La, Lb, phase, clr}, expv());
         end
      end
      total++;
      if ({La, Lb, phase} !== 6'b10_11_11) begin
         bad++;
         $display("FAIL skip_end got=%b want=%b", {La, Lb, phase}, 6'b10_11_11);
      end
   endtask
   task automatic test_latch();
      tick(1, 4'b0000);
      for (int i = 0; i < 14; i++) begin
         tick(0, i < 4 ? 4'b1100 : i < 7 ? 4'b0100 : 4'b0000);
         total++;
         if ({La, Lb, phase, clr} !== expv()) begin
            bad++;
            $display("FAIL latch cyc=%0d got=%b want=%b", i, {La, Lb, phase, clr}, expv());
         end
      end
      total++;
      if ({La, Lb, phase, clr} !== 7'b10_00_10_0) begin
         bad++;
         $display("FAIL latch_end got=%b want=%b", {La, Lb, phase, clr}, 7'b10_00_10_0);
      end
   endtask
   task automatic test_reset_mid_y();
      tick(1, 4'b0000);
      for (int i = 0; i < 5; i++) tick(0, 4'b0100);
      total++;
      if ({La, clr} !== 3'b01_1) begin
         bad++;
         $display("FAIL mid_y_setup got=%b want=%b", {La, clr}, 3'b01_1);
      end
      tick(1, 4'b0100);
      total++;
      if ({La, Lb, phase, clr} !== 7'b00_10_00_0) begin
         bad++;
         $display("FAIL mid_y_reset got=%b want=%b", {La, Lb, phase, clr}, 7'b00_10_00_0);
      end
      for (int i = 0; i < 12; i++) begin
         tick(0, 4'b0100);
         total++;
         if ({La, Lb, phase, clr} !== expv()) begin
            bad++;
            $display("FAIL mid_y_after cyc=%0d got=%b want=%b", i, {La, Lb, phase, clr}, expv());
         end
      end
   endtask
   task automatic test_random();
      logic [3:0] d = 4'b0000;
      logic r;
      tick(1, 4'b0000);
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) d[b] = ~d[b];
         r = $urandom_range(79) == 0;
         tick(r, d);
         total++;
         if ({La, Lb, phase, clr} !== expv()) begin
            bad++;
            $display("FAIL random cyc=%0d d=%b got=%b want=%b", i, d, {La, Lb, phase, clr}, expv());
         end
      end
   endtask
   initial begin
      test_reset();
      test_single_b();
      test_contested();
      test_skip();
      test_latch();
      test_reset_mid_y();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tl_phase_sched.md
# tl_phase_sched

Timed phase scheduler for the four-approach traffic-light intersection with left-turn lanes. It sequences four green phases (A through, A left, B through, B left) with minimum and maximum green times, yellow clearance and all-red clearance. It skips phases with no vehicle demand and drives the 2-bit lamp codes for both roads. It replaces the untimed next-state logic with a counter-driven FSM and sits directly between the road sensors and the lamp drivers.

## Interface
- T_MIN_GREEN, 4: minimum green length in cycles (≥1)
- T_MAX_GREEN, 12: green length after which a contested green is forced off (>T_MIN_GREEN)
- T_YELLOW, 3: yellow length in cycles (≥1)
- T_ALLRED, 2: all-red clearance length in cycles (≥1)
- CW, 5: timer width; 2^CW > T_MAX_GREEN
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- Ta, Tal, Tb, Tbl  in  1 each  demand sensors: A through, A left, B through, B left. Synchronous to clk.
- La, Lb  out  2 each  lamp codes: 00 green, 01 yellow, 10 red, 11 left arrow
- phase  out  2  current or last-served phase: 0 A, 1 AL, 2 B, 3 BL
- clr  out  1  high during yellow and all-red states

## Operation
- States: G (green of phase), Y (yellow), R (all-red). The current phase and the latched next phase are each held in a 2-bit register. The timer cnt (CW bits) clears to 0 on every state change and otherwise increments. In G it saturates at T_MAX_GREEN-1.
- Demand: own = sensor of the current phase. other = OR of the other three sensors.
- G exit: when cnt ≥ T_MIN_GREEN-1 AND other AND (!own OR cnt ≥ T_MAX_GREEN-1), the next state is Y.
  - If other=0, G holds indefinitely, whatever the value of own.
- On the G→Y edge, the next phase is latched as the first phase with demand, searching cyclically after the current phase (A→AL→B→BL→A).
  - A demand change after latching does not alter the choice.
- Y → R when cnt = T_YELLOW-1. R → G of the latched phase when cnt = T_ALLRED-1. phase updates on entry to G.
- Lamp mapping:
  - G with phase A: La=00, Lb=10. G with phase AL: La=11, Lb=10.
  - G with phase B: La=10, Lb=00. G with phase BL: La=10, Lb=11.
  - Y of an A-side phase: La=01, Lb=10. Y of a B-side phase: La=10, Lb=01.
  - R: La=10, Lb=10.
- The outputs are registered or decoded purely from registered state, so there are no combinational sensor→lamp paths.
- Reset (at any time, including mid-Y or mid-R): next state is G, phase=0, latched next phase=0, cnt=0. Outputs after reset: La=00, Lb=10, phase=0, clr=0.

## Timing
- A sensor change is seen at the next edge. The earliest visible lamp change is the cycle after the edge where the exit condition is true.
- Each state is counted from its first cycle.
  - G lasts ≥ T_MIN_GREEN cycles. A contested G lasts ≤ T_MAX_GREEN cycles.
  - Y lasts exactly T_YELLOW cycles and R exactly T_ALLRED cycles.
- Minimum phase-to-phase gap (green end to next green start) = T_YELLOW + T_ALLRED cycles.
- A sensor asserted then dropped before the G exit check is never served. No request memory is kept.
- Simultaneous demands are resolved only by the cyclic search order. The current phase never wins the search.

## Test plan
- Reset, then all sensors 0 for 50 cycles -> La=00, Lb=10, phase=0, clr=0 throughout.
- Tb=1 only from the first post-reset cycle -> 4 cycles with La=00, then 3 cycles with La=01, then 2 cycles with both at 10, then Lb=00, La=10, phase=2.
- Ta=Tb=1 held -> A green exactly 12 cycles, Y 3, R 2, B green 12, Y 3, R 2, then back to A. The 34-cycle period repeats.
- In A green: Ta=0, Tal=0, Tb=0, Tbl=1 -> after min green, Y, R, then Lb=11, La=10, phase=3 (AL and B skipped).
- Tbl=1 and Tb=1 during A green, Tbl dropped during Y -> the latched phase is B (first in search order) and Lb=00. Dropping Tb during R still gives B green.
- Assert reset for 1 cycle during Y (cnt=1) -> next cycle La=00, Lb=10, phase=0, clr=0. Normal min-green timing restarts from 0.
